// File: rtl/image_sample_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : image_sample_fetcher
// Description : Walks the training-image RAM for a programmed number of
//               epochs and streams each word as a 784-bit binarised image and
//               a 10-bit one-hot label over a valid/ready interface. A 2-entry
//               FIFO absorbs the 1-cycle RAM read latency under backpressure.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1            rising-edge clock
//   rst_n        in   1            asynchronous active-low reset
//   start        in   1            run start pulse, ignored while busy
//   num_epochs   in   EPOCH_WIDTH  epochs to run, sampled on start
//   ram_en       out  1            RAM read request
//   ram_we       out  1            RAM write enable, tied low
//   ram_addr     out  ADDR_WIDTH   RAM address
//   ram_dout     in   DATA_WIDTH   RAM read data, valid one cycle after ram_en
//   s_valid      out  1            sample valid
//   s_ready      in   1            consumer ready
//   s_image      out  IMG_BITS     image field of the head sample
//   s_label      out  LABEL_BITS   label field of the head sample
//   s_label_err  out  1            head label is not exactly one-hot
//   s_index      out  ADDR_WIDTH   RAM address of the head sample
//   s_last       out  1            head sample is at address DEPTH-1
//   epoch_cnt    out  EPOCH_WIDTH  epochs fully accepted by the consumer
//   busy         out  1            run in progress
//   done         out  1            one-cycle pulse when the run completes
// ============================================================================
module image_sample_fetcher #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 794,
  parameter int DEPTH       = 60000,
  parameter int IMG_BITS    = 784,
  parameter int LABEL_BITS  = 10,
  parameter int EPOCH_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EPOCH_WIDTH-1:0] num_epochs,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  output logic                   s_valid,
  input  logic                   s_ready,
  output logic [IMG_BITS-1:0]    s_image,
  output logic [LABEL_BITS-1:0]  s_label,
  output logic                   s_label_err,
  output logic [ADDR_WIDTH-1:0]  s_index,
  output logic                   s_last,
  output logic [EPOCH_WIDTH-1:0] epoch_cnt,
  output logic                   busy,
  output logic                   done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [EPOCH_WIDTH-1:0] EPOCH_ONE = EPOCH_WIDTH'(1);
  localparam logic [1:0]             FIFO_CAP  = 2'd2;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic [1:0]             state_q,     state_d;
  logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
  logic [EPOCH_WIDTH-1:0] target_q,    target_d;
  logic [EPOCH_WIDTH-1:0] rd_epoch_q,  rd_epoch_d;
  logic [EPOCH_WIDTH-1:0] epoch_cnt_q, epoch_cnt_d;

  // One outstanding read at most; its index and last flag travel alongside
  // so the returning word can be tagged when it lands in the FIFO.
  logic                   inflight_q;
  logic [ADDR_WIDTH-1:0]  inflight_idx_q;
  logic                   inflight_last_q;

  // --------------------------------------------------------------------------
  // 2-entry sample FIFO
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  fifo_data_q [2];
  logic [ADDR_WIDTH-1:0]  fifo_idx_q  [2];
  logic [1:0]             fifo_last_q;
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;

  // --------------------------------------------------------------------------
  // Datapath / handshake wires
  // --------------------------------------------------------------------------
  logic                   xfer;
  logic                   push;
  logic [1:0]             credit_used;
  logic                   issue;
  logic                   last_rd;
  logic                   final_rd_epoch;
  logic                   final_xfer_epoch;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   label_onehot;

  assign s_valid = (count_q != 2'd0);
  assign xfer    = s_valid & s_ready;
  assign push    = inflight_q;

  // Credits count the entry being popped this cycle as already free; without
  // that the fetcher could only sustain two samples every three cycles under
  // continuous ready. This makes ram_en combinationally dependent on s_ready.
  assign credit_used = count_q - {1'b0, xfer} + {1'b0, inflight_q};
  assign issue       = (state_q == ST_FETCH) && (credit_used < FIFO_CAP);

  assign last_rd          = (addr_q == LAST_ADDR);
  assign final_rd_epoch   = (rd_epoch_q  == (target_q - EPOCH_ONE));
  assign final_xfer_epoch = (epoch_cnt_q == (target_q - EPOCH_ONE));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    target_d    = target_q;
    rd_epoch_d  = rd_epoch_q;
    epoch_cnt_d = epoch_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d    = num_epochs;
          addr_d      = '0;
          rd_epoch_d  = '0;
          epoch_cnt_d = '0;
          state_d     = (num_epochs != '0) ? ST_FETCH : ST_FINISH;
        end
      end
      ST_FETCH: begin
        if (issue && last_rd && final_rd_epoch) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (xfer && s_last && final_xfer_epoch) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // A start in this cycle is deliberately dropped.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address walk; issue only happens in FETCH, so this never collides with
    // the IDLE-state initialisation above.
    if (issue) begin
      if (last_rd) begin
        addr_d     = '0;
        rd_epoch_d = rd_epoch_q + EPOCH_ONE;
      end else begin
        addr_d     = addr_q + ADDR_ONE;
      end
    end

    // Epoch accounting follows the consumer, not the reads, and saturates.
    if (xfer && s_last && (epoch_cnt_q != target_q)) begin
      epoch_cnt_d = epoch_cnt_q + EPOCH_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      target_q        <= '0;
      rd_epoch_q      <= '0;
      epoch_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_idx_q  <= '0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      target_q        <= target_d;
      rd_epoch_q      <= rd_epoch_d;
      epoch_cnt_q     <= epoch_cnt_d;
      inflight_q      <= issue;
      if (issue) begin
        inflight_idx_q  <= addr_q;
        inflight_last_q <= last_rd;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_dout;
        fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      count_q <= count_q + {1'b0, push} - {1'b0, xfer};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign head_data = fifo_data_q[rd_ptr_q];
  assign s_image   = head_data[LABEL_BITS +: IMG_BITS];
  assign s_label   = head_data[LABEL_BITS-1:0];
  assign s_index   = fifo_idx_q[rd_ptr_q];
  assign s_last    = fifo_last_q[rd_ptr_q];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign label_onehot = (s_label != '0) &&
                        ((s_label & (s_label - LABEL_BITS'(1))) == '0);
  assign s_label_err  = s_valid && !label_onehot;

  assign ram_en    = issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = addr_q;
  assign epoch_cnt = epoch_cnt_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_image_sample_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_sample_fetcher
// Description : Self-checking bench for image_sample_fetcher with a small
//               RAM (DEPTH=4) and a queue-based reference of the sample order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_sample_fetcher;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 794;
  localparam int IW    = 784;
  localparam int LW    = 10;
  localparam int EW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [EW-1:0] num_epochs;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_image;
  logic [LW-1:0] s_label;
  logic          s_label_err;
  logic [AW-1:0] s_index;
  logic          s_last;
  logic [EW-1:0] epoch_cnt;
  logic          busy;
  logic          done;

  image_sample_fetcher #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .IMG_BITS   (IW),
    .LABEL_BITS (LW),
    .EPOCH_WIDTH(EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_epochs (num_epochs),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_image    (s_image),
    .s_label    (s_label),
    .s_label_err(s_label_err),
    .s_index    (s_index),
    .s_last     (s_last),
    .epoch_cnt  (epoch_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Training RAM: registered read, one cycle latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr[1:0]];
  end

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int cyc = 0;
  int iss_cnt, xfer_cnt, lasts_seen, done_cnt, err_seen, hold_checks;
  int done_cyc, last_xfer_cyc, first_en_cyc, first_valid_cyc;
  bit mon_en = 1'b0;
  bit hold_pend;
  logic [IW-1:0] h_img;
  logic [LW-1:0] h_lab;
  logic [AW-1:0] h_idx;
  logic          h_last;

  function automatic int ones(input logic [LW-1:0] l);
    int c = 0;
    for (int i = 0; i < LW; i++) c += int'(l[i]);
    return c;
  endfunction

  task automatic prep(input int n);
    exp_q.delete();
    for (int e = 0; e < n; e++)
      for (int k = 0; k < DEPTH; k++) exp_q.push_back(k);
    iss_cnt = 0; xfer_cnt = 0; lasts_seen = 0; done_cnt = 0; err_seen = 0;
    hold_checks = 0; hold_pend = 1'b0;
    done_cyc = -1; last_xfer_cyc = -1; first_en_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic load_mem(input bit bad2);
    logic [IW-1:0] img;
    logic [LW-1:0] lab;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < IW; i++) img[i] = 1'($urandom_range(0, 1));
      lab = LW'(1) << k;
      if (bad2 && k == 2) lab = 10'b0000000011;
      mem[k] = {img, lab};
    end
  endtask

  // --------------------------------------------------------------------------
  // Stream monitor: order, payload, stability, credit and done checks
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    int k;
    logic [DW-1:0] w;
    bit e_err;
    cyc++;
    if (mon_en && rst_n) begin
      n_checks++;
      if (iss_cnt - xfer_cnt > 2)
        $display("FAIL credit: inflight+occupancy=%0d required<=2", iss_cnt - xfer_cnt);
      else n_pass++;

      if (ram_en) begin
        n_checks++;
        if (ram_addr !== AW'(iss_cnt % DEPTH) || ram_we !== 1'b0)
          $display("FAIL ram_addr: got %0d we=%b required %0d we=0", ram_addr, ram_we, iss_cnt % DEPTH);
        else n_pass++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        iss_cnt++;
      end

      if (hold_pend) begin
        n_checks++; hold_checks++;
        if (s_valid !== 1'b1 || s_index !== h_idx || s_image !== h_img ||
            s_label !== h_lab || s_last !== h_last)
          $display("FAIL stall_hold: valid=%b idx=%0d required valid=1 idx=%0d stable", s_valid, s_index, h_idx);
        else n_pass++;
      end
      hold_pend = s_valid && !s_ready;
      if (hold_pend) begin
        h_img = s_image; h_lab = s_label; h_idx = s_index; h_last = s_last;
      end

      if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

      if (s_valid && s_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_xfer: got idx %0d required no transfer", s_index);
        end else begin
          k = exp_q.pop_front();
          w = mem[k];
          e_err = (ones(w[LW-1:0]) != 1);
          if (s_index !== AW'(k) || s_image !== w[DW-1:LW] || s_label !== w[LW-1:0] ||
              s_last !== (k == DEPTH - 1) || s_label_err !== e_err || epoch_cnt !== EW'(lasts_seen))
            $display("FAIL xfer: got idx=%0d lbl=%h last=%b err=%b ep=%0d required idx=%0d lbl=%h last=%b err=%b ep=%0d",
                     s_index, s_label, s_last, s_label_err, epoch_cnt,
                     k, w[LW-1:0], (k == DEPTH - 1), e_err, lasts_seen);
          else n_pass++;
        end
        if (s_label_err) err_seen++;
        if (s_last) lasts_seen++;
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        n_checks++;
        if (exp_q.size() != 0)
          $display("FAIL done_early: %0d samples outstanding required 0", exp_q.size());
        else n_pass++;
      end
    end
  end

  // Drives one run. mode 0: ready high, 1: ready 1,0,0,1, 2: random ready.
  task automatic run_stream(input int n, input int mode, input bit extra);
    s_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_epochs = EW'(n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = extra && (i == 6);
      if (extra && i == 6) num_epochs = 8'd7;
      case (mode)
        0:       s_ready = 1'b1;
        1:       s_ready = (i % 4 == 0) || (i % 4 == 3);
        default: s_ready = 1'($urandom_range(0, 1));
      endcase
      if (done_cnt > 0) break;
    end
    start = 1'b0;
    s_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input int n, input string tag);
    n_checks++;
    if (done_cnt !== 1 || xfer_cnt !== n * DEPTH || iss_cnt !== n * DEPTH || exp_q.size() != 0)
      $display("FAIL %s_totals: done=%0d xfers=%0d reads=%0d required done=1 xfers=%0d reads=%0d",
               tag, done_cnt, xfer_cnt, iss_cnt, n * DEPTH, n * DEPTH);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || epoch_cnt !== EW'(n) || done_cyc !== last_xfer_cyc + 1)
      $display("FAIL %s_end: busy=%b epoch_cnt=%0d done_gap=%0d required busy=0 epoch_cnt=%0d done_gap=1",
               tag, busy, epoch_cnt, done_cyc - last_xfer_cyc, n);
    else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset;
    n_checks++;
    if (ram_en !== 0 || ram_we !== 0 || s_valid !== 0 || busy !== 0 || done !== 0 ||
        epoch_cnt !== 0 || s_index !== 0 || s_last !== 0 || s_label_err !== 0 || s_label !== 0)
      $display("FAIL reset_outputs: en=%b valid=%b busy=%b done=%b ep=%0d required all 0",
               ram_en, s_valid, busy, done, epoch_cnt);
    else n_pass++;
  endtask

  task automatic test_basic;
    load_mem(1'b0);
    prep(2);
    mon_en = 1'b1;
    run_stream(2, 0, 1'b0);
    check_run(2, "basic");
    n_checks++;
    if (first_valid_cyc - first_en_cyc !== 2)
      $display("FAIL latency: got %0d required 2", first_valid_cyc - first_en_cyc);
    else n_pass++;
    n_checks++;
    if (last_xfer_cyc - first_valid_cyc !== 2 * DEPTH - 1)
      $display("FAIL throughput: span %0d required %0d", last_xfer_cyc - first_valid_cyc, 2 * DEPTH - 1);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    load_mem(1'b0);
    prep(3);
    run_stream(3, 1, 1'b0);
    check_run(3, "backpressure");
    n_checks++;
    if (hold_checks == 0) $display("FAIL stall_seen: got 0 stalled cycles required >0");
    else n_pass++;
  endtask

  task automatic test_zero_epochs;
    prep(0);
    @(posedge clk); #1;
    start = 1'b1; num_epochs = '0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_done: done=%b busy=%b required done=1 busy=0", done, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_after: done=%b busy=%b required 0 0", done, busy);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (iss_cnt !== 0 || done_cnt !== 1 || epoch_cnt !== 0)
      $display("FAIL zero_totals: reads=%0d done=%0d ep=%0d required 0 1 0", iss_cnt, done_cnt, epoch_cnt);
    else n_pass++;
  endtask

  task automatic test_label_err;
    load_mem(1'b1);
    prep(2);
    run_stream(2, 2, 1'b0);
    check_run(2, "label_err");
    n_checks++;
    if (err_seen !== 2) $display("FAIL label_err_count: got %0d required 2", err_seen);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int i;
    load_mem(1'b0);
    prep(2);
    s_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_epochs = 8'd2;
    for (i = 0; i < 50 && xfer_cnt < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_checks++;
    if (xfer_cnt !== 3) $display("FAIL mid_reset_reach: got %0d transfers required 3", xfer_cnt);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 0 || s_valid !== 0 || busy !== 0 || done !== 0 || epoch_cnt !== 0 ||
        s_index !== 0 || s_last !== 0 || s_label_err !== 0 || s_image !== '0)
      $display("FAIL async_reset: en=%b valid=%b busy=%b idx=%0d required all 0",
               ram_en, s_valid, busy, s_index);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    prep(1);
    run_stream(1, 2, 1'b0);
    check_run(1, "restart");
  endtask

  task automatic test_start_while_busy;
    load_mem(1'b0);
    prep(2);
    run_stream(2, 1, 1'b1);
    check_run(2, "start_busy");
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 3; r++) begin
      load_mem(1'($urandom_range(0, 1)));
      n = int'($urandom_range(1, 3));
      prep(n);
      run_stream(n, 2, 1'b0);
      check_run(n, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    s_ready = 1'b0;
    num_epochs = '0;
    load_mem(1'b0);
    prep(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_epochs();
    test_label_err();
    test_mid_reset();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_sample_fetcher.md
Name: image_sample_fetcher

Overview:
- Sequencer directly downstream of the training image RAM (794-bit words, 60000 deep, 1-cycle registered read).
- Walks the RAM address space for a programmed number of epochs and splits each word into a 784-bit binarised image and a 10-bit one-hot label.
- Presents each sample to the Boolean-circuit learning engine over a valid/ready stream, with a 2-entry buffer that absorbs the RAM read latency under backpressure.

Parameters:
- ADDR_WIDTH, 16: RAM address width.
- DATA_WIDTH, 794: RAM word width; must equal IMG_BITS + LABEL_BITS.
- DEPTH, 60000: samples per epoch. Last address is DEPTH-1.
- IMG_BITS, 784: image field width.
- LABEL_BITS, 10: label field width.
- EPOCH_WIDTH, 8: epoch counter width.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that starts a run. Ignored while busy=1.
- num_epochs, input, EPOCH_WIDTH: epochs to run. Sampled on start.
- ram_en, output, 1: RAM enable (read request).
- ram_we, output, 1: RAM write enable. Constant 0.
- ram_addr, output, ADDR_WIDTH: RAM address.
- ram_dout, input, DATA_WIDTH: RAM read data. Valid the cycle after ram_en=1.
- s_valid, output, 1: sample valid.
- s_ready, input, 1: consumer ready.
- s_image, output, IMG_BITS: equals ram_dout[793:10] of the sample.
- s_label, output, LABEL_BITS: equals ram_dout[9:0] of the sample.
- s_label_err, output, 1: high with s_valid when s_label is not exactly one-hot.
- s_index, output, ADDR_WIDTH: RAM address the sample came from.
- s_last, output, 1: high with the sample at address DEPTH-1.
- epoch_cnt, output, EPOCH_WIDTH: number of epochs fully accepted by the consumer.
- busy, output, 1: high from the cycle after start until done.
- done, output, 1: one-cycle pulse when the last sample of the final epoch is accepted.

Behaviour:
- Reset values: all outputs 0; buffer empty; FSM in IDLE. Asserting rst_n low mid-run flushes the buffer, drops any in-flight read and returns to IDLE; no done pulse is produced.
- FSM states: IDLE, FETCH, DRAIN, FINISH.
- IDLE -> FETCH: on start when num_epochs != 0. Latches num_epochs, sets addr=0, epoch_cnt=0, busy=1.
- IDLE -> FINISH: on start when num_epochs == 0. No RAM reads occur; done pulses on the following cycle.
- FETCH:
  - Issues a read (ram_en=1, ram_addr=addr) only when (buffer occupancy + reads in flight) < 2.
  - At most one read is issued per cycle.
  - After each read, addr increments, wrapping from DEPTH-1 to 0.
  - After the read of address DEPTH-1 in the final epoch, the FSM moves to DRAIN.
- Read return: the word arriving one cycle after the issue is written into the 2-entry FIFO together with its index and last flag. The credit rule above guarantees the FIFO never overflows.
- Stream handshake:
  - s_valid = FIFO not empty.
  - Payload is driven from the FIFO head and holds stable while s_valid=1 and s_ready=0.
  - A transfer occurs when s_valid and s_ready are both 1.
  - A simultaneous FIFO write and pop in the same cycle is legal; occupancy is unchanged.
- Throughput: with s_ready held at 1, one sample is delivered per cycle after a first-sample latency of 2 cycles from the first ram_en.
- Epoch accounting: epoch_cnt increments on each transfer with s_last=1. It saturates at its latched target and never wraps.
- DRAIN -> FINISH: when the transfer with s_last=1 of the final epoch occurs.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE. A start arriving in the FINISH cycle is ignored.
- s_label_err is a combinational check on the FIFO head: set when popcount(s_label) != 1. It does not stall the stream.
- ram_we is always 0. The block never writes the RAM.

Test Plan:
- Sim with DEPTH=4, num_epochs=2, s_ready=1; RAM word k holds label 1<<k -> 8 transfers with s_index 0,1,2,3,0,1,2,3; s_last at the 4th and 8th; epoch_cnt 1 then 2; single done pulse.
- Same setup with s_ready toggling 1,0,0,1 -> payload stable while stalled; reads in flight + occupancy never exceed 2; no sample lost or duplicated; order preserved.
- num_epochs=0 -> zero ram_en pulses; done pulses one cycle after start; busy returns to 0.
- Word at address 2 carries label 10'b0000000011 -> s_label_err=1 only on index 2; stream continues.
- rst_n asserted low after 3 transfers of epoch 1 -> all outputs 0 immediately (async); restart yields s_index starting at 0 with epoch_cnt=0.
- start pulsed again while busy=1 -> ignored; transfer sequence identical to the run without the extra pulse.
